// File: rtl/mac_pipe_unit_if.sv
// Operand/result handshake bundle for mac_pipe_unit.
// The slave modport is the MAC unit; the master modport is whoever feeds it and drains it.
interface mac_pipe_unit_if #(
    parameter int BIT_WIDTH = 8,
    parameter int ACC_WIDTH = 20
);
    logic [BIT_WIDTH-1:0] i_pix_weight;
    logic [BIT_WIDTH-1:0] i_pix_feature;
    logic                 i_valid;
    logic                 o_ready;
    logic                 i_clear;
    logic [ACC_WIDTH-1:0] o_acc;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_start;
    logic                 o_busy;

    modport master (
        output i_pix_weight, i_pix_feature, i_valid, i_clear, i_ready,
        input  o_ready, o_acc, o_valid, o_start, o_busy
    );

    modport slave (
        input  i_pix_weight, i_pix_feature, i_valid, i_clear, i_ready,
        output o_ready, o_acc, o_valid, o_start, o_busy
    );
endinterface

// File: rtl/mac_pipe_unit.sv
// Pipelined multiply-accumulate: weight/feature pairs go through a MULT_STAGES-deep multiplier,
// and every ACC_LEN products are summed into one result held in a single-entry output register.
module mac_pipe_unit #(
    parameter int BIT_WIDTH   = 8,
    parameter int MULT_STAGES = 2,
    parameter int ACC_LEN     = 9,
    parameter int ACC_WIDTH   = 20,
    parameter bit SIGNED      = 1'b0
) (
    input  logic           i_clk,
    input  logic           i_rst,
    mac_pipe_unit_if.slave bus
);
    localparam int PROD_W = 2 * BIT_WIDTH;
    localparam int CNT_W  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

    logic [CNT_W-1:0]       in_cnt;
    logic [BIT_WIDTH-1:0]   op_weight;
    logic [BIT_WIDTH-1:0]   op_feature;
    logic [MULT_STAGES-1:0] v_pipe;
    logic [MULT_STAGES-1:0] l_pipe;
    logic [PROD_W-1:0]      prod_s1;
    logic [PROD_W-1:0]      exit_prod;
    logic [ACC_WIDTH-1:0]   exit_ext;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic                   closing_inflight;
    logic                   take;
    logic                   exit_valid;
    logic                   exit_last;

    // A pair presented alongside i_clear is dropped so the flushed window starts clean.
    assign take       = bus.i_valid && bus.o_ready && !bus.i_clear;
    assign exit_valid = v_pipe[MULT_STAGES-1];
    assign exit_last  = l_pipe[MULT_STAGES-1];
    assign acc_next   = acc + exit_ext;

    assign bus.o_ready = !i_rst && !((in_cnt == CNT_LAST) &&
                                     (closing_inflight || (bus.o_valid && !bus.i_ready)));
    assign bus.o_busy  = (in_cnt != '0) || (|v_pipe);

    generate
        if (SIGNED) begin : g_signed
            logic signed [PROD_W-1:0] sw;
            logic signed [PROD_W-1:0] sf;
            assign sw       = PROD_W'($signed(op_weight));
            assign sf       = PROD_W'($signed(op_feature));
            assign prod_s1  = sw * sf;
            assign exit_ext = ACC_WIDTH'($signed(exit_prod));
        end else begin : g_unsigned
            assign prod_s1  = PROD_W'(op_weight) * PROD_W'(op_feature);
            assign exit_ext = ACC_WIDTH'(exit_prod);
        end

        // Only last tags in stages that are not leaving this cycle hold back a closing pair.
        if (MULT_STAGES == 1) begin : g_single
            assign exit_prod        = prod_s1;
            assign closing_inflight = 1'b0;
        end else begin : g_deep
            logic [PROD_W-1:0] prod_q [MULT_STAGES-1];
            always_ff @(posedge i_clk) begin
                prod_q[0] <= prod_s1;
                for (int i = 1; i < MULT_STAGES - 1; i++) begin
                    prod_q[i] <= prod_q[i-1];
                end
            end
            assign exit_prod        = prod_q[MULT_STAGES-2];
            assign closing_inflight = |(v_pipe[MULT_STAGES-2:0] & l_pipe[MULT_STAGES-2:0]);
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (take) begin
            op_weight  <= bus.i_pix_weight;
            op_feature <= bus.i_pix_feature;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            in_cnt      <= '0;
            v_pipe      <= '0;
            l_pipe      <= '0;
            acc         <= '0;
            bus.o_acc   <= '0;
            bus.o_valid <= 1'b0;
            bus.o_start <= 1'b0;
        end else begin
            if (bus.o_valid && bus.i_ready) begin
                bus.o_valid <= 1'b0;
            end
            bus.o_start <= take && (in_cnt == '0);
            // Clear flushes the window and everything in flight but leaves a finished result alone.
            if (bus.i_clear) begin
                in_cnt <= '0;
                v_pipe <= '0;
                l_pipe <= '0;
                acc    <= '0;
            end else begin
                v_pipe[0] <= take;
                l_pipe[0] <= take && (in_cnt == CNT_LAST);
                for (int i = 1; i < MULT_STAGES; i++) begin
                    v_pipe[i] <= v_pipe[i-1];
                    l_pipe[i] <= l_pipe[i-1];
                end
                if (take) begin
                    in_cnt <= (in_cnt == CNT_LAST) ? '0 : in_cnt + CNT_W'(1);
                end
                if (exit_valid) begin
                    if (exit_last) begin
                        bus.o_acc   <= acc_next;
                        bus.o_valid <= 1'b1;
                        acc         <= '0;
                    end else begin
                        acc <= acc_next;
                    end
                end
            end
        end
    end
endmodule

// File: doc/mac_pipe_unit.md
Name: mac_pipe_unit

Overview:
Parametrised multiply-accumulate successor to the single-pair pixel multiplier. It accepts a stream of weight/feature pixel pairs with a valid/ready handshake and multiplies them through an inferred MULT_STAGES-deep pipeline, with no vendor IP. It sums ACC_LEN consecutive products into one window result and presents that result on a single-entry output register with valid/ready backpressure. It sits between the column-enable logic and the convolution adder tree, so one kernel window yields one result.

Parameters:
BIT_WIDTH, 8, operand width of weight and feature pixels.
MULT_STAGES, 2, multiplier pipeline depth in cycles (>=1). The input operand register counts as stage 1.
ACC_LEN, 9, products per accumulation window (>=1).
ACC_WIDTH, 20, accumulator/result width. Must be >= 2*BIT_WIDTH + clog2(ACC_LEN).
SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands and result.

Ports:
i_clk  input  1  clock; all logic on rising edge.
i_rst  input  1  synchronous, active-high reset.
i_pix_weight  input  BIT_WIDTH  weight operand.
i_pix_feature  input  BIT_WIDTH  feature operand.
i_valid  input  1  operand pair valid.
o_ready  output  1  unit can accept a pair this cycle.
i_clear  input  1  synchronous flush of the current window.
o_acc  output  ACC_WIDTH  window sum.
o_valid  output  1  o_acc holds an unconsumed result.
i_ready  input  1  downstream consumes o_acc when o_valid is high.
o_start  output  1  one-cycle pulse marking the start of a window.
o_busy  output  1  window in progress or products in flight.

Behaviour:
- Single clock i_clk. Reset is synchronous and active-high on i_rst. Both are fixed.
- Reset: pipeline valid/last tags, accumulator and in_cnt are cleared. o_acc=0, o_valid=0, o_start=0, o_busy=0. o_ready=0 while i_rst=1. Reset mid-operation discards all in-flight products, with no spurious result afterwards.
- Accept occurs when i_valid && o_ready. in_cnt counts accepted pairs modulo ACC_LEN. A pair accepted with in_cnt==ACC_LEN-1 is tagged last. With ACC_LEN=1, every pair is last.
- Multiply: operands are registered on accept (stage 1). The product plus valid/last tags then travel MULT_STAGES-1 further registers. Product width is 2*BIT_WIDTH. With SIGNED=1, operands and product are sign-extended to ACC_WIDTH; otherwise they are zero-extended.
- Accumulate: when a product leaves the pipeline, acc <= acc + product.
  - If the product is tagged last: o_acc <= acc + product, o_valid <= 1, and acc <= 0 in the same cycle.
  - The next window's first product, arriving the next cycle, starts from 0.
- Latency: last pair accepted at cycle T gives o_valid=1 from cycle T+MULT_STAGES+1. Full throughput is one pair per cycle when not stalled.
- Arithmetic is modulo 2^ACC_WIDTH. There is no saturation and no overflow flag.
- Output handshake: o_valid stays high with o_acc stable until i_ready=1, then clears the next cycle. If a new result loads in the same cycle as a consume, o_valid stays 1 with the new value.
- Backpressure: o_ready = !i_rst && !(in_cnt==ACC_LEN-1 && (closing_inflight || (o_valid && !i_ready))). closing_inflight means any last-tagged product is still in the pipeline. Non-last pairs are always accepted. This rule guarantees the output register is never overwritten.
- o_start: pulses 1 for one cycle, the cycle after a pair is accepted with in_cnt==0.
- o_busy: 1 when in_cnt!=0 or any pipeline valid tag is set.
- i_clear:
  - Zeroes in_cnt, acc and all pipeline valid/last tags the next cycle.
  - Does not alter a result already in o_acc/o_valid.
  - An accept in the same cycle as i_clear is dropped.
  - i_rst has priority over i_clear.
- Simultaneous events: a product exiting while a new pair is accepted is normal pipelined operation, and both take effect.

Test Plan:
1. Unsigned pipeline/latency, BIT_WIDTH=8, MULT_STAGES=2, ACC_LEN=3, i_ready=1. Send (1,2),(3,4),(5,6) back-to-back. Required: o_start pulses once, the cycle after the first accept. o_valid rises 3 cycles after the last accept, for 1 cycle, with o_acc=44.
2. Signed mode, SIGNED=1. Send (0xFF,0x05),(0x80,0x80),(0x7F,0xFE). Required: o_acc = -5+16384-254 = 16125. Also send (0xFF,0x01) three times. Required: o_acc = 0xFFFFD (-3 in 20 bits).
3. Backpressure, i_ready=0. Stream six (2,3) pairs. Required:
   - First o_acc=18 is held stable.
   - o_ready=0 when the sixth pair is presented; the 3rd pair of window 2 is not accepted.
   - Pulse i_ready for one cycle: the sixth pair is accepted, and the second result is 18.
   - No result is lost or duplicated.
4. Clear mid-window. Accept (9,9),(9,9), assert i_clear for 1 cycle, then send (1,1)x3. Required: exactly one result, o_acc=3. o_busy=0 the cycle after the clear.
5. Reset mid-operation. With 2 products in flight and an unconsumed o_valid=1, assert i_rst for 1 cycle. Required: o_valid=0, o_acc=0, no result emerges. A subsequent window of (4,5)x3 gives 60.
6. ACC_LEN=1, MULT_STAGES=1. Send (10,10),(20,20),(255,255) back-to-back with i_ready=1. Required: o_acc=100, 400, 65025 on three consecutive cycles, o_valid held high, o_ready always 1.
